ts_sync_sched: RTL and testbench
================================

# ts_sync_sched

Byte-domain frame-sync controller and branch scheduler for the convolutional deinterleaver. It sits between the byte assembler and the I=12, M=17 deinterleaver. It finds and tracks the 204-byte RS packet boundary by sync byte (0x47, or inverted 0xB8), flywheels across corrupted sync bytes, and supplies the deinterleaver with a packet-start pulse and an explicit branch index (0..11) per byte. The deinterleaver commutator therefore never free-runs out of phase.

## Interface
- `PKT_LEN`, 204, bytes per packet; must be a multiple of `BRANCHES`
- `BRANCHES`, 12, deinterleaver branch count
- `LOCK_CNT`, 3, consecutive correctly spaced sync bytes needed to lock (≥2)
- `UNLOCK_CNT`, 4, consecutive missed sync bytes while locked that drop lock (≥1)

- `clk` input 1 — byte clock
- `rst_n` input 1 — reset; **one clock; reset is synchronous and active-low**
- `din_byte` input 8 — byte from serial-to-parallel stage
- `din_valid` input 1 — `din_byte` valid this cycle
- `dout_byte` output 8 — `din_byte` delayed one cycle
- `dout_valid` output 1 — `din_valid` delayed one cycle
- `syn_out` output 1 — high with the output byte at packet position 0 while locked
- `branch_idx` output 4 — deinterleaver branch for the output byte; 0 when not locked
- `locked` output 1 — lock status, aligned with the output byte

## Operation
- Sync byte: `din_byte` equal to 0x47 or 0xB8.
- `pos` counter, 0..PKT_LEN-1, tracks the position of the next byte within the packet.
  - Advances only on `din_valid`.
  - Wraps PKT_LEN-1 → 0.
- `brn` counter, 0..BRANCHES-1, advances and wraps with `pos`. It is forced to 0 whenever `pos` goes to 0.
- FSM states: SEARCH, VERIFY, LOCK. Reset state is SEARCH; all counters reset to 0.
- **SEARCH**
  - On a valid sync byte: go to VERIFY, set hit=1, set `pos`=1, set `brn`=1.
  - On a valid non-sync byte: stay in SEARCH; counters hold 0.
- **VERIFY** (evaluated only on a valid byte at `pos`==0)
  - Sync byte: hit+1. If hit reaches `LOCK_CNT`, go to LOCK with miss=0.
  - Non-sync byte: go to SEARCH. That byte is not re-evaluated.
- **LOCK** (evaluated only on a valid byte at `pos`==0)
  - Sync byte: miss=0.
  - Non-sync byte: miss+1. If miss reaches `UNLOCK_CNT`, go to SEARCH and clear the counters.
- Invalid cycles (`din_valid`=0) never change state, `pos`, `brn`, hit or miss.
- The byte stream is never altered; `dout_byte` is always the delayed `din_byte`.

## Timing
- Every output is registered with 1-cycle latency. All values below refer to the byte presented on the previous cycle.
- Reset values: `dout_byte`=0x00, `dout_valid`=0, `syn_out`=0, `branch_idx`=0, `locked`=0.
- `locked`=1 for every byte consumed in LOCK, plus the confirming sync byte that causes entry to LOCK.
  - That confirming byte is output with `syn_out`=1 and `branch_idx`=0.
- `syn_out`=1 only when `dout_valid`=1, `locked`=1 and the byte was at `pos`==0. This includes flywheeled (missed) sync positions.
- The byte that causes the `UNLOCK_CNT`-th miss is output with `locked`=0, `syn_out`=0, `branch_idx`=0.
- `branch_idx` = `brn` of the byte while locked, otherwise 0. It must equal `pos` mod `BRANCHES` at all times.
- `syn_out`, `branch_idx` and `locked` are all 0 whenever `dout_valid`=0, except that `locked` holds its level through invalid cycles.
- Reset asserted mid-packet: the next edge forces the reset values and SEARCH, and all lock history is discarded.

## Configuration
- `TS_SYNC_INV_CHECK_EN` defined:
  - A 3-bit packet counter is kept in VERIFY and LOCK.
  - 0xB8 counts as a sync only at the first packet of an 8-packet group; 0x47 counts only at the other seven.
  - In SEARCH, only 0xB8 starts VERIFY, and the packet counter is set to 1.
  - A wrong-polarity sync byte counts as a miss in LOCK and as a failure in VERIFY.
- Not defined: 0x47 and 0xB8 are both accepted at any sync position, and no packet counter is implemented.

## Test plan
- **Clean acquisition:** reset, then continuous 204-byte packets, each starting 0x47, filler 0x00 → `locked` rises with the first byte of packet 3. `syn_out` pulses every 204 valid outputs. `branch_idx` cycles 0..11 seventeen times per packet.
- **False sync:** 0x47 at offset 50, then no 0x47 at offset 254 → return to SEARCH; `locked` stays 0.
- **Flywheel:** locked stream, 3 consecutive packets with a corrupted sync byte (0x00) → `locked` stays 1 and `syn_out` still pulses at each boundary. A 4th corrupted sync → `locked`=0 on that byte.
- **Gaps:** locked stream with `din_valid` low for random 1–5 cycles → no change to `pos`, `branch_idx` or lock; outputs show `dout_valid`=0 with `syn_out`=0.
- **Reset mid-packet:** assert `rst_n`=0 at offset 100 of a locked stream → next cycle all outputs are 0. Relock needs 3 further syncs.
- **`TS_SYNC_INV_CHECK_EN`:** stream with 0xB8 every 8th packet locks. The same stream with 0xB8 replaced by 0x47 never locks in SEARCH.

Source files
------------

// File: rtl/ts_sync_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ts_sync_sched_if                                                |
// | Purpose  : Byte-stream bundle between the byte assembler, the frame-sync   |
// |            scheduler and the convolutional deinterleaver.                  |
// | Signals  : din_byte/din_valid   - byte into the scheduler                  |
// |            dout_byte/dout_valid - the same byte, one clock later           |
// |            syn_out              - output byte is packet position 0 (locked)|
// |            branch_idx           - deinterleaver branch of the output byte  |
// |            locked               - lock status aligned with the output byte |
// | Modports : master - byte source / deinterleaver side                       |
// |            slave  - the scheduler (ts_sync_sched)                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ts_sync_sched_if;
  logic [7:0] din_byte;
  logic       din_valid;
  logic [7:0] dout_byte;
  logic       dout_valid;
  logic       syn_out;
  logic [3:0] branch_idx;
  logic       locked;

  modport master (
    output din_byte, din_valid,
    input  dout_byte, dout_valid, syn_out, branch_idx, locked
  );

  modport slave (
    input  din_byte, din_valid,
    output dout_byte, dout_valid, syn_out, branch_idx, locked
  );
endinterface
`default_nettype wire

// File: rtl/ts_sync_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ts_sync_sched                                                   |
// | Purpose  : Frame-sync controller and branch scheduler for the I=12, M=17   |
// |            convolutional deinterleaver. Finds the 204-byte RS packet      |
// |            boundary from the sync byte (0x47 / 0xB8), flywheels over       |
// |            corrupted sync bytes and tags every byte with a packet-start    |
// |            flag and an explicit branch index.                              |
// | Ports    : clk   - byte clock                                              |
// |            rst_n - synchronous active-low reset                            |
// |            bus   - ts_sync_sched_if.slave (din_* in, dout_*/syn_out/       |
// |                    branch_idx/locked out, all registered, 1-cycle latency) |
// | Options  : TS_SYNC_INV_CHECK_EN - enforce 0xB8 on the first packet of each |
// |            8-packet group and 0x47 on the other seven.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ts_sync_sched #(
  parameter int PKT_LEN    = 204,
  parameter int BRANCHES   = 12,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ts_sync_sched_if.slave bus
);

  localparam int c_POS_W  = $clog2(PKT_LEN);
  localparam int c_BRN_W  = $clog2(BRANCHES);
  localparam int c_HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int c_MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [c_POS_W-1:0]  c_POS_LAST  = c_POS_W'(PKT_LEN - 1);
  localparam logic [c_BRN_W-1:0]  c_BRN_LAST  = c_BRN_W'(BRANCHES - 1);
  localparam logic [c_HIT_W-1:0]  c_HIT_LAST  = c_HIT_W'(LOCK_CNT - 1);
  localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(UNLOCK_CNT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_POS_W-1:0]  r_pos;
  logic [c_BRN_W-1:0]  r_brn;
  logic [c_HIT_W-1:0]  r_hit;
  logic [c_MISS_W-1:0] r_miss;

  logic [7:0] r_dout_byte;
  logic       r_dout_valid;
  logic       r_syn;
  logic [3:0] r_branch;
  logic       r_locked;

  logic               w_is_47;
  logic               w_is_b8;
  logic               w_pos0;
  logic               w_start_sync;  // byte may open VERIFY from SEARCH
  logic               w_pos0_sync;   // byte counts as a sync at a packet boundary
  logic [c_POS_W-1:0] w_pos_nxt;
  logic [c_BRN_W-1:0] w_brn_nxt;

  assign w_is_47 = (bus.din_byte == 8'h47);
  assign w_is_b8 = (bus.din_byte == 8'hB8);
  assign w_pos0  = (r_pos == '0);

`ifdef TS_SYNC_INV_CHECK_EN
  // r_pkt is the index (within the 8-packet group) of the packet whose
  // boundary is due next; only packet 0 carries the inverted sync.
  logic [2:0] r_pkt;

  assign w_start_sync = w_is_b8;
  assign w_pos0_sync  = (r_pkt == 3'd0) ? w_is_b8 : w_is_47;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkt <= 3'd0;
    end else if (bus.din_valid) begin
      if (r_state == ST_SEARCH) begin
        if (w_start_sync) begin
          r_pkt <= 3'd1;
        end
      end else if (w_pos0) begin
        r_pkt <= r_pkt + 3'd1;
      end
    end
  end
`else
  assign w_start_sync = w_is_47 | w_is_b8;
  assign w_pos0_sync  = w_is_47 | w_is_b8;
`endif

  // Branch counter restarts with every packet so the commutator phase is
  // re-anchored at each boundary rather than free-running.
  always_comb begin
    w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
    if (w_pos_nxt == '0) begin
      w_brn_nxt = '0;
    end else if (r_brn == c_BRN_LAST) begin
      w_brn_nxt = '0;
    end else begin
      w_brn_nxt = r_brn + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_pos        <= '0;
      r_brn        <= '0;
      r_hit        <= '0;
      r_miss       <= '0;
      r_dout_byte  <= 8'h00;
      r_dout_valid <= 1'b0;
      r_syn        <= 1'b0;
      r_branch     <= 4'd0;
      r_locked     <= 1'b0;
    end else begin
      r_dout_byte  <= bus.din_byte;
      r_dout_valid <= bus.din_valid;
      r_syn        <= 1'b0;
      r_branch     <= 4'd0;
      // On invalid cycles nothing moves and locked keeps its level.
      if (bus.din_valid) begin
        r_pos    <= w_pos_nxt;
        r_brn    <= w_brn_nxt;
        r_locked <= 1'b0;
        case (r_state)
          ST_SEARCH: begin
            if (w_start_sync) begin
              r_state <= ST_VERIFY;
              r_hit   <= c_HIT_W'(1);
              r_pos   <= c_POS_W'(1);
              r_brn   <= c_BRN_W'(1);
            end else begin
              r_pos <= '0;
              r_brn <= '0;
            end
          end

          ST_VERIFY: begin
            if (w_pos0) begin
              if (w_pos0_sync) begin
                r_hit <= r_hit + 1'b1;
                if (r_hit == c_HIT_LAST) begin
                  // Confirming sync is already reported as a locked boundary.
                  r_state  <= ST_LOCK;
                  r_miss   <= '0;
                  r_locked <= 1'b1;
                  r_syn    <= 1'b1;
                end
              end else begin
                r_state <= ST_SEARCH;
                r_pos   <= '0;
                r_brn   <= '0;
                r_hit   <= '0;
              end
            end
          end

          ST_LOCK: begin
            r_locked <= 1'b1;
            r_branch <= 4'(r_brn);
            r_syn    <= w_pos0;  // flywheeled boundaries still pulse
            if (w_pos0) begin
              if (w_pos0_sync) begin
                r_miss <= '0;
              end else if (r_miss == c_MISS_LAST) begin
                r_state  <= ST_SEARCH;
                r_pos    <= '0;
                r_brn    <= '0;
                r_hit    <= '0;
                r_miss   <= '0;
                r_locked <= 1'b0;
                r_syn    <= 1'b0;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end
          end

          default: begin
            r_state <= ST_SEARCH;
            r_pos   <= '0;
            r_brn   <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.dout_byte  = r_dout_byte;
  assign bus.dout_valid = r_dout_valid;
  assign bus.syn_out    = r_syn;
  assign bus.branch_idx = r_branch;
  assign bus.locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ts_sync_sched                                                |
// | Purpose  : Directed self-checking bench for ts_sync_sched: reset values,   |
// |            acquisition, false sync, flywheel, gaps, mid-packet reset and   |
// |            (with TS_SYNC_INV_CHECK_EN) sync polarity checking.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ts_sync_sched;

  logic  clk = 1'b0;
  logic  rst_n;
  int    n_chk = 0;
  int    n_bad = 0;
  string phase = "reset";

  ts_sync_sched_if bus ();

  ts_sync_sched #(
    .PKT_LEN    (204),
    .BRANCHES   (12),
    .LOCK_CNT   (3),
    .UNLOCK_CNT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got=%0h expected=%0h (t=%0t)", phase, tag, got, exp, $time);
    end
  endtask

  // Filler never equals either sync value.
  function automatic logic [7:0] fill(input int k);
    logic [7:0] f;
    f = 8'(k * 7 + 3);
    if (f == 8'h47 || f == 8'hB8) f = 8'h11;
    return f;
  endfunction

  // Present one input cycle, then sample the registered outputs just after the edge.
  task automatic step(input logic [7:0] b, input logic v);
    bus.din_byte  = b;
    bus.din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] b, input logic v, input logic s,
                            input logic [3:0] br, input logic lk);
    check("dout_byte",  {24'd0, bus.dout_byte},  {24'd0, b});
    check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, v});
    check("syn_out",    {31'd0, bus.syn_out},    {31'd0, s});
    check("branch_idx", {28'd0, bus.branch_idx}, {28'd0, br});
    check("locked",     {31'd0, bus.locked},     {31'd0, lk});
  endtask

  // One packet (or its first nbytes) with sync byte sb. lk0 is the expected
  // lock on byte 0, lkr on the remaining bytes. With gaps, invalid cycles of
  // 1..5 are inserted at fixed points inside the packet.
  task automatic pkt(input logic [7:0] sb, input logic lk0, input logic lkr,
                     input int nbytes, input bit gaps);
    logic [7:0] b;
    logic       lk;
    for (int k = 0; k < nbytes; k++) begin
      b  = (k == 0) ? sb : fill(k);
      lk = (k == 0) ? lk0 : lkr;
      step(b, 1'b1);
      expect_out(b, 1'b1, (k == 0) && lk0, lk ? 4'(k % 12) : 4'd0, lk);
      if (gaps && (k % 17 == 5)) begin
        for (int g = 0; g < (k % 5) + 1; g++) begin
          step(8'hA5, 1'b0);
          expect_out(8'hA5, 1'b0, 1'b0, 4'd0, lk);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.din_byte  = 8'h00;
    bus.din_valid = 1'b0;
    step(8'h5A, 1'b1);
    step(8'h00, 1'b0);
    expect_out(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;

`ifndef TS_SYNC_INV_CHECK_EN
    // Lock on the first byte of the third packet; 0xB8 also accepted.
    phase = "acquire";
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'hB8, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);

    // Three flywheeled boundaries keep lock; the fourth miss drops it on that byte.
    phase = "flywheel";
    pkt(8'h00, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'h00, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'h00, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'h00, 1'b0, 1'b0, 204, 1'b0);

    // Lone 0x47 at offset 50 with nothing at 254 must fall back to SEARCH.
    phase = "false_sync";
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      b = (i == 50) ? 8'h47 : fill(i);
      step(b, 1'b1);
      expect_out(b, 1'b1, 1'b0, 4'd0, 1'b0);
    end
    phase = "relock1";
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);

    // Invalid cycles freeze position, branch and lock.
    phase = "gaps";
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b1);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b1);

    // Reset at offset 100 discards all history; three new syncs are needed.
    phase = "mid_reset";
    pkt(8'h47, 1'b1, 1'b1, 100, 1'b0);
    rst_n = 1'b0;
    step(8'h47, 1'b1);
    expect_out(8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    phase = "relock2";
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);
`else
    // Plain 0x47 can never open VERIFY.
    phase = "inv_no_b8";
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    // 0xB8 at group packet 0, 0x47 at packets 1..7: locks at packet 2.
    phase = "inv_group";
    pkt(8'hB8, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b0, 1'b0, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);
    for (int p = 3; p < 8; p++) pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'hB8, 1'b1, 1'b1, 204, 1'b0);
    pkt(8'h47, 1'b1, 1'b1, 204, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
